// File: rtl/mmio_pkg.sv
// Shared types and the default region map for the MMIO bus decoder.
// Region bounds are held 64 bits wide so any ADDR_W up to 64 decodes against the same table.
package mmio_pkg;

    localparam int unsigned N_REGIONS = 5;
    localparam int unsigned REGION_W  = 64;

    localparam int unsigned SLV_SWITCHES = 0;
    localparam int unsigned SLV_KEYS     = 1;
    localparam int unsigned SLV_LED      = 2;
    localparam int unsigned SLV_7SEG     = 3;
    localparam int unsigned SLV_RAM      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [REGION_W-1:0] base;
        logic [REGION_W-1:0] limit;
    } region_t;

    localparam region_t REGION_MAP [N_REGIONS] = '{
        '{base: 64'd0, limit: 64'd0},
        '{base: 64'd1, limit: 64'd1},
        '{base: 64'd2, limit: 64'd2},
        '{base: 64'd3, limit: 64'd7},
        '{base: 64'd8, limit: 64'hFFFF_FFFF_FFFF_FFFF}
    };

    // Inclusive range test folded into one unsigned compare; wraps below base exceed the span.
    function automatic logic region_hit(input logic [REGION_W-1:0] addr, input region_t r);
        return (addr - r.base) <= (r.limit - r.base);
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational region lookup: lowest-indexed matching region wins, hit_c flags any match.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx_c,
    output logic              hit_c
);

    logic [REGION_W-1:0] addr_ext;

    assign addr_ext = REGION_W'(addr);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        idx_c = '0;
        hit_c = 1'b0;
        for (int i = int'(N_REGIONS) - 1; i >= 0; i--) begin
            if (region_hit(addr_ext, REGION_MAP[i])) begin
                idx_c = IDX_W'(i);
                hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_decoder.sv
// Registered MMIO decoder: latches a CPU request, selects one slave, waits for its ready, returns data.
// Define MMIO_TIMEOUT_EN to end accesses that stall for TIMEOUT_CYCLES with cpu_err.
module mmio_bus_decoder
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned N_SLAVES       = 5,
    parameter int unsigned DEFAULT_SLAVE  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic                         busy,
    output logic [N_SLAVES-1:0]          slv_sel,
    output logic                         slv_we,
    output logic [ADDR_W-1:0]            slv_addr,
    output logic [DATA_W-1:0]            slv_wdata,
    input  logic [N_SLAVES*DATA_W-1:0]   slv_rdata,
    input  logic [N_SLAVES-1:0]          slv_ready
);

    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                cpu_err_q, cpu_err_d;
    logic                busy_q, busy_d;
    logic [N_SLAVES-1:0] slv_sel_q, slv_sel_d;
    logic                slv_we_q, slv_we_d;
    logic [ADDR_W-1:0]   slv_addr_q, slv_addr_d;
    logic [DATA_W-1:0]   slv_wdata_q, slv_wdata_d;

    logic [IDX_W-1:0]    dec_idx_c;
    logic                dec_hit_c;
    logic [IDX_W-1:0]    new_idx_c;
    logic [DATA_W-1:0]   sel_rdata_c;
    logic                sel_ready_c;
    logic                tmo_hit_c;

    mmio_addr_decode #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr_decode (
        .addr  (cpu_addr),
        .idx_c (dec_idx_c),
        .hit_c (dec_hit_c)
    );

    assign new_idx_c = dec_hit_c ? dec_idx_c : IDX_W'(DEFAULT_SLAVE);

    // Only the latched slave's ready and data are visible to the FSM.
    always_comb begin
        sel_rdata_c = '0;
        sel_ready_c = 1'b0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata_c = slv_rdata[i*DATA_W +: DATA_W];
                sel_ready_c = slv_ready[i];
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Fires on the ACCESS cycle that would bring the count to TIMEOUT_CYCLES.
    assign tmo_hit_c = (state_q == ACCESS) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == ACCESS) && !sel_ready_c && !tmo_hit_c) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
    assign tmo_hit_c  = 1'b0;
`endif

    // Next-state and next-output logic; every output is a flop.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        cpu_err_d   = 1'b0;
        slv_sel_d   = slv_sel_q;
        slv_we_d    = slv_we_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d     = ACCESS;
                    idx_d       = new_idx_c;
                    slv_sel_d   = N_SLAVES'(1) << new_idx_c;
                    slv_we_d    = cpu_we;
                    slv_addr_d  = cpu_addr;
                    slv_wdata_d = cpu_wdata;
                end
            end
            ACCESS: begin
                if (sel_ready_c) begin
                    state_d     = RESP;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = slv_we_q ? '0 : sel_rdata_c;
                    slv_sel_d   = '0;
                end else if (tmo_hit_c) begin
                    state_d     = RESP;
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = '0;
                    slv_sel_d   = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                slv_sel_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            slv_sel_q   <= '0;
            slv_we_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            busy_q      <= busy_d;
            slv_sel_q   <= slv_sel_d;
            slv_we_q    <= slv_we_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign busy      = busy_q;
    assign slv_sel   = slv_sel_q;
    assign slv_we    = slv_we_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Directed bench for mmio_bus_decoder; the stall test adapts to MMIO_TIMEOUT_EN.
module tb_mmio_bus_decoder;

    logic         clk;
    logic         reset;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_err;
    logic         busy;
    logic [4:0]   slv_sel;
    logic         slv_we;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [159:0] slv_rdata;
    logic [4:0]   slv_ready;

    int checks = 0;
    int fails  = 0;

    logic [31:0] dec_addr [5] = '{32'd8, 32'hFFFF_FFFF, 32'd7, 32'd1, 32'd2};
    logic [4:0]  dec_sel  [5] = '{5'b10000, 5'b10000, 5'b01000, 5'b00010, 5'b00100};
    logic [31:0] dec_rd   [5] = '{32'h4444_4444, 32'h4444_4444, 32'h3333_3333,
                                  32'h1111_1111, 32'h2222_2222};

    mmio_bus_decoder #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .N_SLAVES       (5),
        .DEFAULT_SLAVE  (4),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .busy      (busy),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns in the first ACCESS cycle.
    task automatic start_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick();
        cpu_req   = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        slv_ready = '0;
        slv_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_00A5};
        tick();
        tick();
        checks++; if ({cpu_ready, cpu_err, busy, slv_sel, slv_we} !== 9'd0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 0", {cpu_ready, cpu_err, busy, slv_sel, slv_we});
        end
        checks++; if ({cpu_rdata, slv_addr, slv_wdata} !== 96'd0) begin
            fails++; $display("FAIL reset_data: got %h expected 0", {cpu_rdata, slv_addr, slv_wdata});
        end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_read_switches();
        start_access(1'b0, 32'd0, 32'd0);
        checks++; if (slv_sel !== 5'b00001) begin
            fails++; $display("FAIL rd_sel: got %b expected 00001", slv_sel);
        end
        checks++; if (busy !== 1'b1 || cpu_ready !== 1'b0) begin
            fails++; $display("FAIL rd_access_flags: got busy=%b ready=%b expected busy=1 ready=0", busy, cpu_ready);
        end
        slv_ready = 5'b00001;
        tick();
        slv_ready = '0;
        checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0000_00A5) begin
            fails++; $display("FAIL rd_resp: got ready=%b err=%b rdata=%h expected 1 0 000000a5", cpu_ready, cpu_err, cpu_rdata);
        end
        checks++; if (slv_sel !== 5'b00000) begin
            fails++; $display("FAIL rd_resp_sel: got %b expected 00000", slv_sel);
        end
        tick();
        checks++; if (cpu_ready !== 1'b0 || busy !== 1'b0 || cpu_rdata !== 32'h0000_00A5) begin
            fails++; $display("FAIL rd_after: got ready=%b busy=%b rdata=%h expected 0 0 000000a5", cpu_ready, busy, cpu_rdata);
        end
    endtask

    task automatic test_write_7seg();
        start_access(1'b1, 32'd5, 32'h0000_003C);
        checks++; if (slv_sel !== 5'b01000 || slv_we !== 1'b1) begin
            fails++; $display("FAIL wr_sel_we: got sel=%b we=%b expected 01000 1", slv_sel, slv_we);
        end
        checks++; if (slv_addr !== 32'd5 || slv_wdata !== 32'h0000_003C) begin
            fails++; $display("FAIL wr_addr_data: got addr=%h wdata=%h expected 00000005 0000003c", slv_addr, slv_wdata);
        end
        slv_ready = 5'b01000;
        tick();
        slv_ready = '0;
        checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'd0 || cpu_err !== 1'b0) begin
            fails++; $display("FAIL wr_resp: got ready=%b rdata=%h err=%b expected 1 00000000 0", cpu_ready, cpu_rdata, cpu_err);
        end
        tick();
    endtask

    task automatic test_decode();
        for (int i = 0; i < 5; i++) begin
            start_access(1'b0, dec_addr[i], 32'd0);
            checks++; if (slv_sel !== dec_sel[i]) begin
                fails++; $display("FAIL dec_sel[%0d]: got %b expected %b", i, slv_sel, dec_sel[i]);
            end
            slv_ready = ~dec_sel[i];
            tick();
            tick();
            checks++; if (cpu_ready !== 1'b0 || slv_sel !== dec_sel[i] || busy !== 1'b1) begin
                fails++; $display("FAIL dec_wrong_ready[%0d]: got ready=%b sel=%b busy=%b expected 0 %b 1", i, cpu_ready, slv_sel, busy, dec_sel[i]);
            end
            slv_ready = dec_sel[i];
            tick();
            slv_ready = '0;
            checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== dec_rd[i]) begin
                fails++; $display("FAIL dec_resp[%0d]: got ready=%b rdata=%h expected 1 %h", i, cpu_ready, cpu_rdata, dec_rd[i]);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int early;
`ifdef MMIO_TIMEOUT_EN
        early = 0;
        start_access(1'b0, 32'd3, 32'd0);
        for (int k = 1; k < 15; k++) begin
            tick();
            if (cpu_ready !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin
            fails++; $display("FAIL tmo_early: got %0d early responses expected 0", early);
        end
        tick();
        checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'd0 || slv_sel !== 5'd0) begin
            fails++; $display("FAIL tmo_resp: got ready=%b err=%b rdata=%h sel=%b expected 1 1 00000000 00000", cpu_ready, cpu_err, cpu_rdata, slv_sel);
        end
        tick();
        checks++; if (cpu_ready !== 1'b0 || cpu_err !== 1'b0) begin
            fails++; $display("FAIL tmo_after: got ready=%b err=%b expected 0 0", cpu_ready, cpu_err);
        end
        start_access(1'b0, 32'd3, 32'd0);
        for (int k = 1; k < 15; k++) tick();
        slv_ready = 5'b01000;
        tick();
        slv_ready = '0;
        checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h3333_3333) begin
            fails++; $display("FAIL tmo_ready_wins: got ready=%b err=%b rdata=%h expected 1 0 33333333", cpu_ready, cpu_err, cpu_rdata);
        end
        tick();
`else
        early = 0;
        start_access(1'b0, 32'd3, 32'd0);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cpu_ready !== 1'b0 || busy !== 1'b1 || cpu_err !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin
            fails++; $display("FAIL stall_wait: got %0d bad cycles expected 0", early);
        end
        slv_ready = 5'b01000;
        tick();
        slv_ready = '0;
        checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h3333_3333) begin
            fails++; $display("FAIL stall_resp: got ready=%b err=%b rdata=%h expected 1 0 33333333", cpu_ready, cpu_err, cpu_rdata);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid_access();
        int spurious;
        spurious = 0;
        start_access(1'b1, 32'd8, 32'h0000_DEAD);
        tick();
        checks++; if (slv_sel !== 5'b10000 || slv_addr !== 32'd8) begin
            fails++; $display("FAIL rst_pre: got sel=%b addr=%h expected 10000 00000008", slv_sel, slv_addr);
        end
        reset     = 1'b1;
        slv_ready = 5'b10000;
        #1;
        checks++; if ({cpu_ready, cpu_err, busy, slv_sel, slv_we} !== 9'd0 || {cpu_rdata, slv_addr, slv_wdata} !== 96'd0) begin
            fails++; $display("FAIL rst_mid: got ctrl=%b data=%h expected all 0", {cpu_ready, cpu_err, busy, slv_sel, slv_we}, {cpu_rdata, slv_addr, slv_wdata});
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (cpu_ready !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin
            fails++; $display("FAIL rst_no_ready: got %0d bad cycles expected 0", spurious);
        end
        slv_ready = '0;
        start_access(1'b0, 32'd2, 32'd0);
        checks++; if (slv_sel !== 5'b00100) begin
            fails++; $display("FAIL rst_next_sel: got %b expected 00100", slv_sel);
        end
        slv_ready = 5'b00100;
        tick();
        slv_ready = '0;
        checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h2222_2222) begin
            fails++; $display("FAIL rst_next_resp: got ready=%b rdata=%h expected 1 22222222", cpu_ready, cpu_rdata);
        end
        tick();
    endtask

    // Request held high with every slave ready: responses land every third cycle.
    task automatic test_back_to_back();
        logic [8:0]  pulses;
        logic [31:0] addrs [3];
        logic [4:0]  sels  [3];
        logic [31:0] rds   [3];
        addrs = '{32'd0, 32'd2, 32'd9};
        sels  = '{5'b00001, 5'b00100, 5'b10000};
        rds   = '{32'h0000_00A5, 32'h2222_2222, 32'h4444_4444};
        pulses    = '0;
        slv_ready = 5'b11111;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = addrs[0];
        for (int c = 0; c < 9; c++) begin
            tick();
            pulses[c] = cpu_ready;
            if (c % 3 == 0) begin
                checks++; if (slv_sel !== sels[c/3]) begin
                    fails++; $display("FAIL b2b_sel[%0d]: got %b expected %b", c/3, slv_sel, sels[c/3]);
                end
            end
            if (c % 3 == 1) begin
                checks++; if (cpu_rdata !== rds[c/3]) begin
                    fails++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", c/3, cpu_rdata, rds[c/3]);
                end
                if (c < 7) cpu_addr = addrs[c/3 + 1];
                else cpu_req = 1'b0;
            end
        end
        checks++; if (pulses !== 9'b010010010) begin
            fails++; $display("FAIL b2b_pulses: got %b expected 010010010", pulses);
        end
        tick();
        tick();
        checks++; if (busy !== 1'b0 || cpu_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_idle: got busy=%b ready=%b expected 0 0", busy, cpu_ready);
        end
        slv_ready = '0;
    endtask

    initial begin
        test_reset();
        test_read_switches();
        test_write_7seg();
        test_decode();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
